parity_frame_tx: RTL
====================

# parity_frame_tx

Serial transmitter for parity-protected data frames. It accepts one `{data, parity}` frame per valid/ready handshake from the parity generator stage and shifts it onto a single idle-high line. The line format is one start bit, the data bits LSB first, the parity bit, and one stop bit. It sits directly downstream of the parity generator and drives the board-level serial output.

## Interface
- `WIDTH`, 32: data bits per frame; the frame input is `WIDTH+1` bits.
- `CLKS_PER_BIT`, 16: clock cycles each line bit is held; legal range ≥ 2.
- `clk` input 1: single clock, rising edge.
- `reset_p` input 1: asynchronous, active-high reset.
- `frame_in` input WIDTH+1: `{data[WIDTH-1:0], parity}`; bit 0 is parity, bits `[WIDTH:1]` are data.
- `frame_valid` input 1: `frame_in` is valid this cycle.
- `frame_ready` output 1: the block can accept a frame; high only in IDLE.
- `tx` output 1: serial line, registered, idle level 1.
- `busy` output 1: high from the accept edge until the return to IDLE.
- `done` output 1: one-cycle pulse when the stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP; binary encoded, local to the module.
- IDLE:
  - `tx`=1, `frame_ready`=1, `busy`=0.
  - On `frame_valid && frame_ready` at a rising edge:
    - latch `frame_in` into the shift register;
    - clear the baud counter and bit index;
    - go to START, with `tx`←0 and `busy`←1 on the same edge.
- START: hold `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA; `tx`←data bit 0 (`frame_in[1]`).
- DATA:
  - Each bit is held for `CLKS_PER_BIT` cycles.
  - Bit index runs 0..`WIDTH-1` and drives `frame_in[1+index]`.
  - After bit `WIDTH-1`, go to PARITY with `tx`←`frame_in[0]`.
- PARITY: hold for `CLKS_PER_BIT` cycles, then go to STOP with `tx`←1.
- STOP:
  - Hold `tx`=1 for `CLKS_PER_BIT` cycles.
  - Then go to IDLE; `done`←1 for exactly one cycle and `busy`←0.
- Baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT-1`, wraps to 0 on each bit boundary; no off-by-one at the wrap.
- Bit index: `$clog2(WIDTH)` bits; it must not wrap inside DATA.
- The block does not check or recompute parity; `frame_in[0]` is sent as given.
- `frame_in` is sampled only on the accept edge; later changes are ignored.
- `frame_valid` while busy is ignored (`frame_ready`=0); the upstream stage must hold it.

## Timing
- Reset values: `tx`=1, `frame_ready`=1, `busy`=0, `done`=0, state=IDLE, counters=0.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronous); the frame is discarded and no `done` pulse is produced.
- Latency: `tx` falls on the accept edge itself.
- Frame duration: `(WIDTH+3)*CLKS_PER_BIT` cycles from the accept edge to the edge that raises `done`.
- `done` and `frame_ready` rise on the same edge. A frame can be accepted on the next edge, which gives back-to-back frames with no extra idle bit.
- Simultaneous `done` and a valid upstream frame: the accept happens one edge after `done` rises, never on the STOP→IDLE edge.

## Structure
- Shared package `frame_pkg` holds the line-level constants used here and by the future receiver:
  - `LINE_IDLE`=1, `START_BIT`=0, `STOP_BIT`=1;
  - frame-length helper `FRAME_BITS = WIDTH+3`.
- One natural sub-module: `baud_tick_gen`. It counts to `CLKS_PER_BIT`, emits a one-cycle `bit_end` tick, and has a synchronous clear driven on accept. The FSM and shift register stay in the top module.

## Test plan
Bench parameters: `WIDTH`=8, `CLKS_PER_BIT`=4.
- Reset, then idle 20 cycles → `tx`=1, `frame_ready`=1, `busy`=0, `done` never pulses.
- `frame_in`=9'h14A (data A5, parity 0), single valid pulse → `tx` sequence 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles; `done` pulses 44 cycles after accept.
- `frame_in`=9'h00F (data 07, parity 1) → `tx` sequence 0,1,1,1,0,0,0,0,0,1,1; `busy` is high for exactly 44 cycles.
- Hold `frame_valid` high with 9'h14A then 9'h00F queued → second start bit begins one cycle after `done`; `frame_in` changes during frame 1 do not alter its bits.
- Assert `reset_p` at cycle 17 of a frame → `tx`=1 within the same cycle; `busy`=0, no `done`; the next frame transmits correctly.
- Sweep `CLKS_PER_BIT`=2 and 16 with data 8'hFF (parity 0) → every bit width is exact and the parity bit is 0 after eight 1s.

Source files
------------

// File: rtl/frame_pkg.sv
// Line-level constants shared by the parity frame transmitter and its future receiver.
package frame_pkg;

  // Serial line levels
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Line bits in one frame: start + data + parity + stop
  function automatic int frame_bits(input int width);
    return width + 3;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while enabled and flags the
// last cycle of each bit so the FSM can advance on that edge.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_p,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // Count 0..CLKS_PER_BIT-1 and wrap; a clear restarts the bit period.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (r_count == CNT_LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CNT_ONE;
      end
    end
  end

  assign o_bit_end = i_enable && (r_count == CNT_LAST);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial transmitter for {data, parity} frames on an idle-high line:
// start bit, data LSB first, parity bit as given, stop bit.
//
// Handshake: a frame is accepted on any rising edge where frame_valid and
// frame_ready are both high; frame_ready is high only in IDLE, so the
// upstream stage must hold frame_valid and frame_in until it is accepted.
module parity_frame_tx
  import frame_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           reset_p,
  input  logic [WIDTH:0] frame_in,
  input  logic           frame_valid,
  output logic           frame_ready,
  output logic           tx,
  output logic           busy,
  output logic           done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_data;
  logic               r_parity;
  logic [IDX_W-1:0]   r_bit_idx;
  logic               r_tx;
  logic               r_busy;
  logic               r_done;

  logic               w_tx_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_load;
  logic               w_shift;
  logic               w_idx_inc;
  logic               w_bit_end;
  logic               w_tick_en;

  assign w_tick_en = (r_state != S_IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk      (clk),
    .reset_p  (reset_p),
    .i_clear  (w_load),
    .i_enable (w_tick_en),
    .o_bit_end(w_bit_end)
  );

  // Next-state and next-output decode; the line bit is decided one edge ahead
  // so that tx comes straight from a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_idx_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt   = LINE_IDLE;
        w_busy_nxt = 1'b0;
        if (frame_valid) begin
          w_state_nxt = S_START;
          w_tx_nxt    = START_BIT;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_data[0];
          w_shift     = 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == LAST_IDX) begin
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_parity;
          end else begin
            w_tx_nxt  = r_data[0];
            w_shift   = 1'b1;
            w_idx_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = STOP_BIT;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = LINE_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, line and status registers; reset forces the line idle at once.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state <= S_IDLE;
      r_tx    <= LINE_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Frame capture on accept, then shift data right so bit 0 is always next.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_bit_idx <= '0;
    end else if (w_load) begin
      r_data    <= frame_in[WIDTH:1];
      r_parity  <= frame_in[0];
      r_bit_idx <= '0;
    end else begin
      if (w_shift) begin
        r_data <= r_data >> 1;
      end
      if (w_idx_inc) begin
        r_bit_idx <= r_bit_idx + IDX_ONE;
      end
    end
  end

  assign frame_ready = (r_state == S_IDLE);
  assign tx          = r_tx;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
